// File: rtl/atm_pkg.sv
// Shared types and helpers for the ATM PIN-entry logic.
package atm_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } pin_state_e;

    localparam int PIN_DIGITS = 4;

    // Index of the set bit; only called when exactly one bit is set.
    function automatic logic [3:0] onehot_to_bcd(input logic [9:0] onehot);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < 10; i++) begin
            if (onehot[i]) v = 4'(i);
        end
        return v;
    endfunction

endpackage

// File: rtl/pin_entry_key_edge.sv
// key_edge: rising-edge detector of parameterised width against a registered copy.
module key_edge #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_level,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_prev <= '0;
        else        r_prev <= i_level;
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/pin_entry.sv
// pin_entry: 4-digit PIN capture from a raw keypad with enter/cancel handling.
// Optional inactivity timeout is built only when PIN_TIMEOUT_EN is defined.
//
//   state     | meaning
//   S_IDLE    | no session; waits for pass_en (re-armed by pass_en low after a PIN)
//   S_COLLECT | capturing digits, watching enter/cancel/timeout
//   S_DONE    | single cycle presenting the PIN with pass_valid
module pin_entry
    import atm_pkg::*;
#(
    parameter int P_WIDTH = 16,
    parameter int T_WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pass_en,
    input  logic [9:0]         i_digit_buttons,
    input  logic               i_enter_button,
    input  logic               i_cancel_button,
    input  logic [T_WIDTH-1:0] i_threshold,
    output logic [P_WIDTH-1:0] o_in_password,
    output logic               o_pass_valid,
    output logic [2:0]         o_digit_count,
    output logic               o_key_error,
    output logic               o_short_entry,
    output logic               o_pin_timeout
);

    pin_state_e         r_state, w_state_nxt;
    logic [P_WIDTH-1:0] r_pin, w_pin_nxt;
    logic [2:0]         r_count, w_count_nxt;
    logic               r_rearm, w_rearm_nxt;
    logic               r_key_error, w_key_error_nxt;
    logic               r_short_entry, w_short_entry_nxt;
    logic               r_pin_timeout, w_pin_timeout_nxt;
    logic [9:0]         w_digit_edge;
    logic [1:0]         w_ctrl_edge;
    logic               w_enter_edge, w_cancel_edge;
    logic               w_multi_key, w_single_key;
    logic               w_digit_accept, w_timeout_hit;

    key_edge #(.W(10)) u_digit_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_level (i_digit_buttons),
        .o_rise  (w_digit_edge)
    );

    key_edge #(.W(2)) u_ctrl_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_level ({i_cancel_button, i_enter_button}),
        .o_rise  (w_ctrl_edge)
    );

    assign w_enter_edge  = w_ctrl_edge[0];
    assign w_cancel_edge = w_ctrl_edge[1];
    assign w_multi_key   = ($countones(w_digit_edge) > 1);
    assign w_single_key  = $onehot(w_digit_edge);

    // Priority in COLLECT: cancel/pass_en drop, timeout, enter, then digits.
    always_comb begin
        w_state_nxt       = r_state;
        w_pin_nxt         = r_pin;
        w_count_nxt       = r_count;
        w_rearm_nxt       = r_rearm;
        w_key_error_nxt   = 1'b0;
        w_short_entry_nxt = 1'b0;
        w_pin_timeout_nxt = 1'b0;
        w_digit_accept    = 1'b0;
        if (!i_pass_en) w_rearm_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_pass_en && !r_rearm && !w_cancel_edge) begin
                    w_state_nxt = S_COLLECT;
                    w_pin_nxt   = '0;
                    w_count_nxt = '0;
                end
            end
            S_COLLECT: begin
                if (w_cancel_edge || !i_pass_en) begin
                    w_state_nxt = S_IDLE;
                    w_pin_nxt   = '0;
                    w_count_nxt = '0;
                end else if (w_timeout_hit) begin
                    w_state_nxt       = S_IDLE;
                    w_pin_nxt         = '0;
                    w_count_nxt       = '0;
                    w_pin_timeout_nxt = 1'b1;
                end else if (w_enter_edge) begin
                    if (r_count == 3'(PIN_DIGITS)) begin
                        w_state_nxt = S_DONE;
                        w_count_nxt = '0;
                        w_rearm_nxt = 1'b1;
                    end else begin
                        w_short_entry_nxt = 1'b1;
                        w_pin_nxt         = '0;
                        w_count_nxt       = '0;
                    end
                end else if (w_multi_key) begin
                    w_key_error_nxt = 1'b1;
                end else if (w_single_key && r_count < 3'(PIN_DIGITS)) begin
                    w_pin_nxt      = {r_pin[P_WIDTH-5:0], onehot_to_bcd(w_digit_edge)};
                    w_count_nxt    = r_count + 3'd1;
                    w_digit_accept = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_pin_nxt   = '0;
                w_count_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pin_nxt   = '0;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= S_IDLE;
            r_pin         <= '0;
            r_count       <= '0;
            r_rearm       <= 1'b0;
            r_key_error   <= 1'b0;
            r_short_entry <= 1'b0;
            r_pin_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pin         <= w_pin_nxt;
            r_count       <= w_count_nxt;
            r_rearm       <= w_rearm_nxt;
            r_key_error   <= w_key_error_nxt;
            r_short_entry <= w_short_entry_nxt;
            r_pin_timeout <= w_pin_timeout_nxt;
        end
    end

`ifdef PIN_TIMEOUT_EN
    logic [T_WIDTH-1:0] r_timer, w_timer_nxt;

    // Fires on the cycle the count would reach the threshold; zero disables.
    assign w_timeout_hit = (r_state == S_COLLECT) && (i_threshold != '0) &&
                           (r_timer == i_threshold - T_WIDTH'(1));

    always_comb begin
        w_timer_nxt = '0;
        if (r_state == S_COLLECT && w_state_nxt == S_COLLECT && !w_digit_accept)
            w_timer_nxt = r_timer + T_WIDTH'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_timer <= '0;
        else        r_timer <= w_timer_nxt;
    end
`else
    logic w_unused_threshold;
    assign w_unused_threshold = ^i_threshold;
    assign w_timeout_hit      = 1'b0;
`endif

    assign o_pass_valid  = (r_state == S_DONE);
    assign o_in_password = (r_state == S_DONE) ? r_pin : '0;
    assign o_digit_count = r_count;
    assign o_key_error   = r_key_error;
    assign o_short_entry = r_short_entry;
    assign o_pin_timeout = r_pin_timeout;

endmodule

// File: tb/tb_pin_entry.sv
// Self-checking bench for pin_entry: directed scenarios plus randomized key sequences
// compared against a digit-queue model of the PIN session.
module tb_pin_entry;

    typedef struct packed {
        logic        pv;
        logic [15:0] pw;
        logic [2:0]  cnt;
        logic        ke;
        logic        se;
        logic        to;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst, pass_en, enter, cancel;
    logic [9:0]  digits;
    logic [31:0] threshold;
    logic [15:0] pw;
    logic        pv, ke, se, to;
    logic [2:0]  cnt;

    int n_checks = 0;
    int n_errors = 0;
    int m_q[$];

    always #5 clk = ~clk;

    pin_entry dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pass_en       (pass_en),
        .i_digit_buttons (digits),
        .i_enter_button  (enter),
        .i_cancel_button (cancel),
        .i_threshold     (threshold),
        .o_in_password   (pw),
        .o_pass_valid    (pv),
        .o_digit_count   (cnt),
        .o_key_error     (ke),
        .o_short_entry   (se),
        .o_pin_timeout   (to)
    );

    function automatic snap_t sample();
        snap_t s;
        s = {pv, pw, cnt, ke, se, to};
        return s;
    endfunction

    function automatic logic [9:0] btn(input int d);
        logic [9:0] one;
        one = 10'd1;
        return one << d;
    endfunction

    // Press for one cycle, release; a = just after the press edge, b = one cycle later.
    task automatic press(input logic [9:0] m, input logic en, input logic ca,
                         output snap_t a, output snap_t b);
        @(negedge clk);
        digits = m; enter = en; cancel = ca;
        @(negedge clk);
        a = sample();
        digits = '0; enter = 1'b0; cancel = 1'b0;
        @(negedge clk);
        b = sample();
    endtask

    task automatic open_session();
        @(negedge clk);
        pass_en = 1'b0;
        @(negedge clk);
        pass_en = 1'b1;
        @(negedge clk);
        m_q.delete();
    endtask

    // Session model: a queue of captured digits; the PIN is the digits read as hex.
    task automatic model_act(input logic [9:0] m, input logic en, input logic ca,
                             output snap_t ea, output snap_t eb);
        int n, d, v;
        n = 0; d = 0;
        for (int i = 0; i < 10; i++) if (m[i]) begin n++; d = i; end
        ea = '0;
        if (ca) begin
            m_q.delete();
        end else if (en) begin
            if (m_q.size() == 4) begin
                v = 0;
                foreach (m_q[i]) v = v * 16 + m_q[i];
                ea.pv = 1'b1;
                ea.pw = 16'(v);
            end else begin
                ea.se = 1'b1;
            end
            m_q.delete();
        end else if (n >= 2) begin
            ea.ke = 1'b1;
        end else if (n == 1 && m_q.size() < 4) begin
            m_q.push_back(d);
        end
        ea.cnt = 3'(m_q.size());
        eb = '0;
        eb.cnt = 3'(m_q.size());
    endtask

    task automatic test_reset();
        snap_t s;
        rst = 1'b0; pass_en = 1'b0; enter = 1'b0; cancel = 1'b0;
        digits = '0; threshold = '0;
        repeat (3) @(negedge clk);
        s = sample();
        n_checks++;
        if (s !== snap_t'(0)) begin n_errors++; $display("FAIL reset_hold got=%h exp=0", s); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        s = sample();
        n_checks++;
        if (s !== snap_t'(0)) begin n_errors++; $display("FAIL reset_release got=%h exp=0", s); end
    endtask

    task automatic test_pin_ok();
        snap_t a, b;
        open_session();
        for (int i = 1; i <= 4; i++) begin
            press(btn(i), 1'b0, 1'b0, a, b);
            n_checks++;
            if (a.cnt !== 3'(i)) begin n_errors++; $display("FAIL ok_count got=%0d exp=%0d", a.cnt, i); end
        end
        press('0, 1'b1, 1'b0, a, b);
        n_checks++;
        if (a.pv !== 1'b1 || a.pw !== 16'h1234) begin
            n_errors++; $display("FAIL ok_pin got pv=%b pw=%h exp pv=1 pw=1234", a.pv, a.pw);
        end
        n_checks++;
        if (b !== snap_t'(0)) begin n_errors++; $display("FAIL ok_after got=%h exp=0", b); end
    endtask

    task automatic test_short_entry();
        snap_t a, b;
        open_session();
        press(btn(9), 1'b0, 1'b0, a, b);
        press(btn(8), 1'b0, 1'b0, a, b);
        press('0, 1'b1, 1'b0, a, b);
        n_checks++;
        if (a.se !== 1'b1 || a.cnt !== 3'd0 || a.pv !== 1'b0) begin
            n_errors++; $display("FAIL short_pulse got=%h exp se=1 cnt=0 pv=0", a);
        end
        n_checks++;
        if (b.se !== 1'b0) begin n_errors++; $display("FAIL short_one_cycle got=%b exp=0", b.se); end
        for (int i = 5; i <= 8; i++) press(btn(i), 1'b0, 1'b0, a, b);
        press('0, 1'b1, 1'b0, a, b);
        n_checks++;
        if (a.pv !== 1'b1 || a.pw !== 16'h5678) begin
            n_errors++; $display("FAIL short_retry got pv=%b pw=%h exp pv=1 pw=5678", a.pv, a.pw);
        end
    endtask

    task automatic test_key_error();
        snap_t a, b;
        open_session();
        press(10'b0000001010, 1'b0, 1'b0, a, b);
        n_checks++;
        if (a.ke !== 1'b1 || a.cnt !== 3'd0) begin
            n_errors++; $display("FAIL keyerr_pulse got ke=%b cnt=%0d exp ke=1 cnt=0", a.ke, a.cnt);
        end
        n_checks++;
        if (b.ke !== 1'b0) begin n_errors++; $display("FAIL keyerr_one_cycle got=%b exp=0", b.ke); end
        for (int i = 1; i <= 5; i++) press(btn(i), 1'b0, 1'b0, a, b);
        n_checks++;
        if (a !== snap_t'({1'b0, 16'h0, 3'd4, 3'b000})) begin
            n_errors++; $display("FAIL fifth_digit got=%h exp cnt=4 no pulses", a);
        end
        press('0, 1'b1, 1'b0, a, b);
        n_checks++;
        if (a.pv !== 1'b1 || a.pw !== 16'h1234) begin
            n_errors++; $display("FAIL fifth_pin got pv=%b pw=%h exp pv=1 pw=1234", a.pv, a.pw);
        end
    endtask

    task automatic test_cancel_enter();
        snap_t a, b;
        open_session();
        for (int i = 1; i <= 3; i++) press(btn(i), 1'b0, 1'b0, a, b);
        press('0, 1'b1, 1'b1, a, b);
        n_checks++;
        if (a !== snap_t'(0)) begin n_errors++; $display("FAIL cancel_enter got=%h exp=0", a); end
        press(btn(7), 1'b0, 1'b0, a, b);
        n_checks++;
        if (a.cnt !== 3'd1) begin n_errors++; $display("FAIL cancel_reopen got=%0d exp=1", a.cnt); end
    endtask

    task automatic test_enter_digit_and_hold();
        snap_t a, b;
        open_session();
        for (int i = 1; i <= 4; i++) press(btn(i), 1'b0, 1'b0, a, b);
        press(btn(5), 1'b1, 1'b0, a, b);
        n_checks++;
        if (a.pv !== 1'b1 || a.pw !== 16'h1234) begin
            n_errors++; $display("FAIL enter_digit got pv=%b pw=%h exp pv=1 pw=1234", a.pv, a.pw);
        end
        // pass_en still high: no new session until it drops
        press(btn(2), 1'b0, 1'b0, a, b);
        n_checks++;
        if (b.cnt !== 3'd0) begin n_errors++; $display("FAIL rearm_block got=%0d exp=0", b.cnt); end
        open_session();
        @(negedge clk);
        digits = btn(3);
        repeat (4) @(negedge clk);
        digits = '0;
        @(negedge clk);
        n_checks++;
        if (cnt !== 3'd1) begin n_errors++; $display("FAIL hold_one_edge got=%0d exp=1", cnt); end
        pass_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cnt !== 3'd0) begin n_errors++; $display("FAIL pass_en_drop got=%0d exp=0", cnt); end
    endtask

    task automatic test_reset_mid();
        snap_t a, b;
        open_session();
        press(btn(1), 1'b0, 1'b0, a, b);
        press(btn(2), 1'b0, 1'b0, a, b);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a = sample();
        n_checks++;
        if (a !== snap_t'(0)) begin n_errors++; $display("FAIL reset_mid got=%h exp=0", a); end
        rst = 1'b1;
        @(negedge clk);
        press(btn(4), 1'b0, 1'b0, a, b);
        press(btn(3), 1'b0, 1'b0, a, b);
        press(btn(2), 1'b0, 1'b0, a, b);
        press(btn(1), 1'b0, 1'b0, a, b);
        press('0, 1'b1, 1'b0, a, b);
        n_checks++;
        if (a.pv !== 1'b1 || a.pw !== 16'h4321) begin
            n_errors++; $display("FAIL reset_fresh got pv=%b pw=%h exp pv=1 pw=4321", a.pv, a.pw);
        end
    endtask

    task automatic test_timeout();
        logic exp_to;
        threshold = 32'd15;
        open_session();
        @(negedge clk);
        digits = btn(6);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) digits = '0;
`ifdef PIN_TIMEOUT_EN
            exp_to = (k == 16);
`else
            exp_to = 1'b0;
`endif
            n_checks++;
            if (to !== exp_to) begin
                n_errors++; $display("FAIL timeout_k%0d got=%b exp=%b", k, to, exp_to);
            end
        end
`ifdef PIN_TIMEOUT_EN
        n_checks++;
        if (cnt !== 3'd0) begin n_errors++; $display("FAIL timeout_clear got=%0d exp=0", cnt); end
`else
        n_checks++;
        if (cnt !== 3'd1) begin n_errors++; $display("FAIL notimeout_keep got=%0d exp=1", cnt); end
`endif
        threshold = '0;
        open_session();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (to !== 1'b0) begin
                n_checks++; n_errors++; $display("FAIL timeout_disabled got=1 exp=0");
            end
        end
    endtask

    task automatic test_random();
        snap_t a, b, ea, eb;
        logic [9:0] m;
        logic en, ca;
        int r, d1, d2;
        threshold = '0;
        open_session();
        for (int it = 0; it < 300; it++) begin
            r  = $urandom_range(0, 99);
            d1 = $urandom_range(0, 9);
            d2 = (d1 + $urandom_range(1, 9)) % 10;
            m = '0; en = 1'b0; ca = 1'b0;
            if (r < 60)      m = btn(d1);
            else if (r < 70) m = btn(d1) | btn(d2);
            else if (r < 82) en = 1'b1;
            else if (r < 87) ca = 1'b1;
            else if (r < 92) begin en = 1'b1; m = btn(d1); end
            else if (r < 96) begin en = 1'b1; ca = 1'b1; end
            else             begin ca = 1'b1; m = btn(d1) | btn(d2); end
            model_act(m, en, ca, ea, eb);
            press(m, en, ca, a, b);
            n_checks++;
            if (a !== ea) begin
                n_errors++; $display("FAIL rand_press it=%0d got=%h exp=%h", it, a, ea);
            end
            n_checks++;
            if (b !== eb) begin
                n_errors++; $display("FAIL rand_after it=%0d got=%h exp=%h", it, b, eb);
            end
            if (ea.pv) open_session();
        end
    endtask

    initial begin
        test_reset();
        test_pin_ok();
        test_short_entry();
        test_key_error();
        test_cancel_enter();
        test_enter_digit_and_hold();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
